pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage. Holds the architectural fetch PC and issues fetch requests to instruction memory over a valid/ready handshake. Applies trap and branch/jump redirects by priority, inserts a counted number of pipeline bubbles, and honours a backend stall. A redirect that arrives while a request is outstanding is buffered until that request is accepted.

## Interface
Parameters:
- XLEN, 64: PC / address width.
- PC_INIT, 64'h8000_0000: reset PC. Truncated to XLEN.
- ILEN_BYTES, 4: sequential PC increment.
- BUBBLE_W, 4: width of the bubble count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; one clock, synchronous reset.
- stall_i  in  1  backend hold; blocks issuing a new request.
- bubble_i  in  BUBBLE_W  number of bubble cycles requested; 0 means none.
- redirect_valid_i  in  1  branch/jump resolved taken.
- redirect_pc_i  in  XLEN  redirect target.
- trap_valid_i  in  1  trap/exception redirect; highest priority.
- trap_pc_i  in  XLEN  trap target.
- ireq_valid_o  out  1  fetch request valid (registered).
- ireq_addr_o  out  XLEN  fetch address; always equals pc_o.
- ireq_ready_i  in  1  instruction memory accepts the request.
- pc_o  out  XLEN  current fetch PC.
- bubble_cnt_o  out  BUBBLE_W  remaining bubble cycles.
- pend_valid_o  out  1  a redirect is buffered.

## Operation
- Reset values: pc_o=PC_INIT, ireq_valid_o=0, bubble_cnt_o=0, pend_valid_o=0, state=IDLE.
- States:
  - IDLE: entered only after reset; goes to RUN on the next cycle.
  - RUN: issues requests.
  - BUBBLE: ireq_valid_o is held at 0.
- accept = ireq_valid_o & ireq_ready_i.
- Event = trap_valid_i | redirect_valid_i. Target = trap_pc_i if trap_valid_i, else redirect_pc_i.
- Request stability: while ireq_valid_o=1 and accept=0, pc_o and ireq_valid_o must not change, regardless of any other input.
- Event while a request is outstanding and not accepted: load the pending register.
  - A trap overwrites a pending redirect.
  - A redirect does not overwrite a pending trap.
  - A later trap overwrites an earlier trap; likewise for redirects.
- Event when no request is outstanding, or in the accept cycle: pc_o <= target at once. The incoming event wins over the pending register; the pending register is cleared.
- Accept with pending_valid and no new event: pc_o <= pending target, pending cleared.
- Accept with no event and no pending: pc_o <= pc_o + ILEN_BYTES, modulo 2^XLEN.
- Bubbles are applied only when no event is present in the cycle.
  - bubble_i≠0 in RUN with no outstanding request, or in the accept cycle: go to BUBBLE, bubble_cnt <= bubble_i.
  - In BUBBLE, bubble_cnt decrements each cycle. When it equals 1, the next state is RUN and the count becomes 0.
  - bubble_i is ignored while in BUBBLE.
  - An event in BUBBLE aborts the bubbles: count <= 0, state <= RUN, pc_o <= target.
- ireq_valid_o next value:
  - 1 if held by the stability rule.
  - Otherwise 1 iff the next state is RUN and stall_i=0.
- stall_i never retracts an asserted request. It freezes bubble_cnt and the BUBBLE state.

## Timing
- Redirect latency: an event at cycle t with no outstanding request gives pc_o=target and ireq_valid_o=1 at t+1 (stall_i=0).
- Buffered redirect: applied on the cycle after accept. No intermediate sequential address is issued.
- First request after reset: reset deasserts at t; IDLE at t+1; ireq_valid_o=1 with PC_INIT at t+2.
- Bubble count N, entered at t: ireq_valid_o=0 for cycles t+1 .. t+N; valid again at t+N+1.
- Back-to-back accepts with ireq_ready_i held at 1: one new address per cycle.
- Reset mid-operation overrides everything, including an outstanding request and pending state.

## Test plan
- Reset: PC_INIT=0x8000_0000, ready=1 → addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles.
- Redirect while not ready: valid at 0x100, ready=0; redirect_pc_i=0x200 pulsed → pend_valid_o=1 and ireq_addr_o stays 0x100. ready=1 → next address 0x200, never 0x104.
- Priority: redirect 0x200 and trap 0x300 in the same cycle → pc_o=0x300. Pending trap 0x300, then redirect 0x400 → 0x300 is issued.
- Bubbles: bubble_i=3 on accept at 0x10 → valid low for 3 cycles, then address 0x14. With stall_i high for 2 of those cycles, valid is low for 5 cycles.
- Abort: bubble_i=5, then redirect 0x80 on the second bubble cycle → valid=1 with 0x80 on the next cycle, bubble_cnt_o=0.
- Wrap and reset: pc=0xFFFF_FFFF_FFFF_FFFC accepted → 0x0. Reset asserted while valid=1 and ready=0 → outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen -- fetch-stage program-counter generator.
//
// Holds the architectural fetch PC and presents it to instruction memory over
// a valid/ready handshake. Trap and branch/jump redirects are applied by
// priority. A redirect that arrives while a request is outstanding is parked
// in a one-entry pending register until that request is accepted. A counted
// run of bubble cycles can be inserted, and a backend stall holds off new
// requests.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   stall_i             backend hold: no new request, bubble count frozen
//   bubble_i            number of bubble cycles to insert (0 = none)
//   redirect_valid_i    taken branch/jump, target on redirect_pc_i
//   trap_valid_i        trap redirect (wins over redirect), target on trap_pc_i
//   ireq_valid_o        registered fetch request valid
//   ireq_addr_o         fetch address (identical to pc_o)
//   ireq_ready_i        instruction memory accepts the request
//   pc_o                current fetch PC
//   bubble_cnt_o        bubble cycles still to run
//   pend_valid_o        a redirect is parked in the pending register
module pc_gen #(
    parameter int          XLEN       = 64,
    parameter logic [63:0] PC_INIT    = 64'h8000_0000,
    parameter int          ILEN_BYTES = 4,
    parameter int          BUBBLE_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_i,
    input  logic [BUBBLE_W-1:0] bubble_i,
    input  logic                redirect_valid_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    input  logic                trap_valid_i,
    input  logic [XLEN-1:0]     trap_pc_i,
    output logic                ireq_valid_o,
    output logic [XLEN-1:0]     ireq_addr_o,
    input  logic                ireq_ready_i,
    output logic [XLEN-1:0]     pc_o,
    output logic [BUBBLE_W-1:0] bubble_cnt_o,
    output logic                pend_valid_o
);

    localparam logic [XLEN-1:0] PC_RESET = PC_INIT[XLEN-1:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } state_t;

    state_t              state;
    logic [XLEN-1:0]     pc;
    logic                ireq_valid;
    logic [BUBBLE_W-1:0] bubble_cnt;
    logic                pend_valid;
    logic                pend_trap;
    logic [XLEN-1:0]     pend_pc;

    logic                accept;
    logic                hold;
    logic                evt;
    logic [XLEN-1:0]     target;
    logic [XLEN-1:0]     pc_inc;

    assign accept = ireq_valid & ireq_ready_i;
    // A presented but unaccepted request must stay frozen on the bus.
    assign hold   = ireq_valid & ~ireq_ready_i;
    assign evt    = trap_valid_i | redirect_valid_i;
    assign target = trap_valid_i ? trap_pc_i : redirect_pc_i;
    assign pc_inc = pc + XLEN'(ILEN_BYTES);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= PC_RESET;
            ireq_valid <= 1'b0;
            bubble_cnt <= '0;
            pend_valid <= 1'b0;
            pend_trap  <= 1'b0;
        end else if (hold) begin
            // PC and valid are untouched; only the pending slot can change.
            // A parked trap is never displaced by a plain redirect.
            if (trap_valid_i) begin
                pend_valid <= 1'b1;
                pend_trap  <= 1'b1;
                pend_pc    <= trap_pc_i;
            end else if (redirect_valid_i && !(pend_valid && pend_trap)) begin
                pend_valid <= 1'b1;
                pend_trap  <= 1'b0;
                pend_pc    <= redirect_pc_i;
            end
        end else if (evt) begin
            // A live event beats whatever is parked, and aborts any bubbles.
            pc         <= target;
            pend_valid <= 1'b0;
            pend_trap  <= 1'b0;
            bubble_cnt <= '0;
            state      <= RUN;
            ireq_valid <= ~stall_i;
        end else begin
            case (state)
                IDLE: begin
                    state      <= RUN;
                    ireq_valid <= ~stall_i;
                end
                BUBBLE: begin
                    ireq_valid <= 1'b0;
                    if (!stall_i) begin
                        if (bubble_cnt <= BUBBLE_W'(1)) begin
                            bubble_cnt <= '0;
                            state      <= RUN;
                            ireq_valid <= 1'b1;
                        end else begin
                            bubble_cnt <= bubble_cnt - BUBBLE_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        pc         <= pend_valid ? pend_pc : pc_inc;
                        pend_valid <= 1'b0;
                        pend_trap  <= 1'b0;
                    end
                    if (bubble_i != '0) begin
                        state      <= BUBBLE;
                        bubble_cnt <= bubble_i;
                        ireq_valid <= 1'b0;
                    end else begin
                        ireq_valid <= ~stall_i;
                    end
                end
                default: begin
                    state      <= RUN;
                    ireq_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ireq_valid_o = ireq_valid;
    assign ireq_addr_o  = pc;
    assign pc_o         = pc;
    assign bubble_cnt_o = bubble_cnt;
    assign pend_valid_o = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- self-checking bench for pc_gen (default parameters).
// Directed scenarios use hand-derived constants; a randomized run compares
// every cycle against a behavioural model of the fetch PC rules.
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic [3:0]  bubble_i;
    logic        redirect_valid_i;
    logic [63:0] redirect_pc_i;
    logic        trap_valid_i;
    logic [63:0] trap_pc_i;
    logic        ireq_valid_o;
    logic [63:0] ireq_addr_o;
    logic        ireq_ready_i;
    logic [63:0] pc_o;
    logic [3:0]  bubble_cnt_o;
    logic        pend_valid_o;

    int checks   = 0;
    int failures = 0;

    pc_gen dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall_i),
        .bubble_i         (bubble_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .trap_valid_i     (trap_valid_i),
        .trap_pc_i        (trap_pc_i),
        .ireq_valid_o     (ireq_valid_o),
        .ireq_addr_o      (ireq_addr_o),
        .ireq_ready_i     (ireq_ready_i),
        .pc_o             (pc_o),
        .bubble_cnt_o     (bubble_cnt_o),
        .pend_valid_o     (pend_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change right after a falling edge; outputs are read at the
    // falling edge, half a period after the rising edge that updated them.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall_i = 0; bubble_i = 0; redirect_valid_i = 0; redirect_pc_i = 0;
        trap_valid_i = 0; trap_pc_i = 0; ireq_ready_i = 0;
    endtask

    // Leaves the DUT in its IDLE cycle (reset released, not yet clocked).
    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick();
        if (pc_o !== 64'h8000_0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 64'h8000_0000); end
        checks++;
        if (ireq_valid_o !== 1'b0 || bubble_cnt_o !== 4'd0 || pend_valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got valid=%b cnt=%0d pend=%b exp 0/0/0", ireq_valid_o, bubble_cnt_o, pend_valid_o);
        end
        checks++;
        reset = 0; ireq_ready_i = 1;
        tick();
        if (ireq_valid_o !== 1'b1 || ireq_addr_o !== 64'h8000_0000) begin
            failures++; $display("FAIL first_req got valid=%b addr=%h exp 1/%h", ireq_valid_o, ireq_addr_o, 64'h8000_0000);
        end
        checks++;
        tick();
        if (ireq_valid_o !== 1'b1 || ireq_addr_o !== 64'h8000_0004) begin
            failures++; $display("FAIL seq_req1 got valid=%b addr=%h exp 1/%h", ireq_valid_o, ireq_addr_o, 64'h8000_0004);
        end
        checks++;
        tick();
        if (ireq_valid_o !== 1'b1 || ireq_addr_o !== 64'h8000_0008) begin
            failures++; $display("FAIL seq_req2 got valid=%b addr=%h exp 1/%h", ireq_valid_o, ireq_addr_o, 64'h8000_0008);
        end
        checks++;
    endtask

    task automatic test_pending_redirect();
        do_reset();
        redirect_valid_i = 1; redirect_pc_i = 64'h100;
        tick();
        if (ireq_valid_o !== 1'b1 || pc_o !== 64'h100) begin
            failures++; $display("FAIL redirect_idle got valid=%b pc=%h exp 1/100", ireq_valid_o, pc_o);
        end
        checks++;
        redirect_pc_i = 64'h200;
        tick();
        redirect_valid_i = 0;
        if (pend_valid_o !== 1'b1 || ireq_addr_o !== 64'h100 || ireq_valid_o !== 1'b1) begin
            failures++; $display("FAIL pend_load got pend=%b addr=%h valid=%b exp 1/100/1", pend_valid_o, ireq_addr_o, ireq_valid_o);
        end
        checks++;
        tick();
        if (ireq_addr_o !== 64'h100 || ireq_valid_o !== 1'b1) begin
            failures++; $display("FAIL pend_stable got addr=%h valid=%b exp 100/1", ireq_addr_o, ireq_valid_o);
        end
        checks++;
        ireq_ready_i = 1;
        tick();
        if (ireq_addr_o !== 64'h200 || pend_valid_o !== 1'b0 || ireq_valid_o !== 1'b1) begin
            failures++; $display("FAIL pend_apply got addr=%h pend=%b valid=%b exp 200/0/1", ireq_addr_o, pend_valid_o, ireq_valid_o);
        end
        checks++;
    endtask

    task automatic test_priority();
        do_reset();
        redirect_valid_i = 1; redirect_pc_i = 64'h200;
        trap_valid_i = 1; trap_pc_i = 64'h300;
        tick();
        if (pc_o !== 64'h300) begin failures++; $display("FAIL prio_same_cycle got=%h exp=300", pc_o); end
        checks++;
        do_reset();
        redirect_valid_i = 1; redirect_pc_i = 64'h100;
        tick();
        redirect_valid_i = 0; trap_valid_i = 1; trap_pc_i = 64'h300;
        tick();
        trap_valid_i = 0; redirect_valid_i = 1; redirect_pc_i = 64'h400;
        tick();
        redirect_valid_i = 0;
        if (pend_valid_o !== 1'b1 || pc_o !== 64'h100) begin
            failures++; $display("FAIL prio_pend_hold got pend=%b pc=%h exp 1/100", pend_valid_o, pc_o);
        end
        checks++;
        ireq_ready_i = 1;
        tick();
        if (pc_o !== 64'h300) begin failures++; $display("FAIL prio_pend_trap got=%h exp=300", pc_o); end
        checks++;
    endtask

    // Presents 0x10 and accepts it with bubble_i = n; returns on the first bubble cycle.
    task automatic enter_bubble(input logic [3:0] n);
        do_reset();
        redirect_valid_i = 1; redirect_pc_i = 64'h10;
        tick();
        redirect_valid_i = 0; ireq_ready_i = 1; bubble_i = n;
        tick();
        bubble_i = 0;
    endtask

    task automatic test_bubbles();
        int low;
        enter_bubble(4'd3);
        if (ireq_valid_o !== 1'b0 || bubble_cnt_o !== 4'd3) begin
            failures++; $display("FAIL bubble_enter got valid=%b cnt=%0d exp 0/3", ireq_valid_o, bubble_cnt_o);
        end
        checks++;
        low = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ireq_valid_o === 1'b1) break;
            low++;
        end
        if (low !== 3 || ireq_addr_o !== 64'h14) begin
            failures++; $display("FAIL bubble_len got low=%0d addr=%h exp 3/14", low, ireq_addr_o);
        end
        checks++;
        enter_bubble(4'd3);
        low = 1;
        for (int i = 0; i < 20; i++) begin
            stall_i = (i < 2);
            tick();
            if (ireq_valid_o === 1'b1) break;
            low++;
        end
        stall_i = 0;
        if (low !== 5 || ireq_addr_o !== 64'h14) begin
            failures++; $display("FAIL bubble_stall_len got low=%0d addr=%h exp 5/14", low, ireq_addr_o);
        end
        checks++;
    endtask

    task automatic test_abort();
        enter_bubble(4'd5);
        tick();
        if (bubble_cnt_o !== 4'd4 || ireq_valid_o !== 1'b0) begin
            failures++; $display("FAIL abort_pre got cnt=%0d valid=%b exp 4/0", bubble_cnt_o, ireq_valid_o);
        end
        checks++;
        redirect_valid_i = 1; redirect_pc_i = 64'h80;
        tick();
        redirect_valid_i = 0;
        if (ireq_valid_o !== 1'b1 || ireq_addr_o !== 64'h80 || bubble_cnt_o !== 4'd0) begin
            failures++; $display("FAIL abort got valid=%b addr=%h cnt=%0d exp 1/80/0", ireq_valid_o, ireq_addr_o, bubble_cnt_o);
        end
        checks++;
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        redirect_valid_i = 1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid_i = 0; ireq_ready_i = 1;
        tick();
        if (pc_o !== 64'h0 || ireq_valid_o !== 1'b1) begin
            failures++; $display("FAIL wrap got pc=%h valid=%b exp 0/1", pc_o, ireq_valid_o);
        end
        checks++;
        do_reset();
        redirect_valid_i = 1; redirect_pc_i = 64'h100;
        tick();
        redirect_pc_i = 64'h200;
        tick();
        redirect_valid_i = 0;
        reset = 1;
        tick();
        reset = 0;
        if (pc_o !== 64'h8000_0000 || ireq_valid_o !== 1'b0 || pend_valid_o !== 1'b0 || bubble_cnt_o !== 4'd0) begin
            failures++; $display("FAIL reset_mid got pc=%h valid=%b pend=%b cnt=%0d exp 80000000/0/0/0", pc_o, ireq_valid_o, pend_valid_o, bubble_cnt_o);
        end
        checks++;
    endtask

    // Behavioural model: the fetch engine is described by how many bubble
    // cycles remain, whether it has left reset yet, and an optional parked
    // target tagged with its priority (2 = trap, 1 = redirect, 0 = empty).
    logic [63:0] m_pc, m_pend_pc;
    logic        m_valid, m_started;
    int          m_bub, m_pend_prio;

    task automatic model_step();
        bit held, took, ev;
        logic [63:0] tgt;
        int prio;
        if (reset) begin
            m_pc = 64'h8000_0000; m_valid = 0; m_bub = 0; m_pend_prio = 0; m_started = 0;
            return;
        end
        held = m_valid && !ireq_ready_i;
        took = m_valid && ireq_ready_i;
        ev   = trap_valid_i || redirect_valid_i;
        tgt  = trap_valid_i ? trap_pc_i : redirect_pc_i;
        prio = trap_valid_i ? 2 : (redirect_valid_i ? 1 : 0);
        if (held) begin
            if (ev && prio >= m_pend_prio) begin m_pend_prio = prio; m_pend_pc = tgt; end
        end else if (ev) begin
            m_pc = tgt; m_pend_prio = 0; m_bub = 0; m_started = 1; m_valid = !stall_i;
        end else if (m_bub > 0) begin
            if (!stall_i) m_bub--;
            m_valid = (m_bub == 0);
        end else begin
            if (took) begin
                m_pc = (m_pend_prio != 0) ? m_pend_pc : m_pc + 64'd4;
                m_pend_prio = 0;
            end
            if (m_started && bubble_i != 0) begin
                m_bub = int'(bubble_i); m_valid = 0;
            end else begin
                m_valid = !stall_i;
            end
            m_started = 1;
        end
    endtask

    task automatic test_random();
        int shown = 0;
        do_reset();
        m_pc = 64'h8000_0000; m_valid = 0; m_bub = 0; m_pend_prio = 0; m_started = 0; m_pend_pc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset            = ($urandom_range(0, 99) == 0);
            ireq_ready_i     = $urandom_range(0, 1);
            stall_i          = ($urandom_range(0, 3) == 0);
            redirect_valid_i = ($urandom_range(0, 6) == 0);
            trap_valid_i     = ($urandom_range(0, 12) == 0);
            redirect_pc_i    = {$urandom, $urandom} & ~64'h3;
            trap_pc_i        = {$urandom, $urandom} & ~64'h3;
            bubble_i         = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 6)) : 4'd0;
            model_step();
            tick();
            if (pc_o !== m_pc || ireq_addr_o !== m_pc || ireq_valid_o !== m_valid ||
                bubble_cnt_o !== 4'(m_bub) || pend_valid_o !== (m_pend_prio != 0)) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cyc=%0d got pc=%h addr=%h valid=%b cnt=%0d pend=%b exp pc=%h valid=%b cnt=%0d pend=%b",
                             cyc, pc_o, ireq_addr_o, ireq_valid_o, bubble_cnt_o, pend_valid_o,
                             m_pc, m_valid, m_bub, (m_pend_prio != 0));
                end
            end
            checks++;
        end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        tick();
        test_reset();
        test_pending_redirect();
        test_priority();
        test_bubbles();
        test_abort();
        test_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
